// File: rtl/led_serial_receiver.sv
`default_nettype none
// ============================================================================
//  Module   : led_serial_receiver
//  Purpose  : Far end of the serial LED link. It oversamples PSCLK, data and
//             latch, shifts bits in MSB first, and commits the word on the
//             latch rising edge. The behaviour matches a 74HC595 chain.
//  Options  : LED_RX_FRAME_CHECK_EN enables rejection of short or overrun
//             frames.
//  Revision : 1.0  initial release
// ============================================================================
module led_serial_receiver #(
   parameter int WIDTH       = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic                       i_CLK,
   input  logic                       i_RESET,
   input  logic                       i_SCLK,
   input  logic                       i_SData,
   input  logic                       i_SLatch,
   output logic [WIDTH-1:0]           o_Data,
   output logic                       o_Valid,
   output logic [$clog2(WIDTH+1)-1:0] o_BitCount,
   output logic                       o_FrameErr
);

   localparam int             CW        = $clog2(WIDTH + 1);
   localparam logic [CW-1:0]  CNT_FULL  = CW'(WIDTH);
   localparam logic [CW-1:0]  CNT_ONE   = CW'(1);
   localparam int             MASK_CYC  = SYNC_STAGES + 1;
   localparam int             MW        = $clog2(MASK_CYC + 1);
   localparam logic [MW-1:0]  MASK_LAST = MW'(MASK_CYC);

   logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
   logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
   logic [SYNC_STAGES-1:0] latch_sync_q, latch_sync_d;
   logic                   sclk_prev_q, sclk_prev_d;
   logic                   latch_prev_q, latch_prev_d;
   logic [MW-1:0]          mask_q, mask_d;
   logic [WIDTH-1:0]       shreg_q, shreg_d;
   logic [CW-1:0]          count_q, count_d;
   logic                   ovr_q, ovr_d;
   logic [WIDTH-1:0]       data_q, data_d;
   logic                   valid_q, valid_d;
`ifdef LED_RX_FRAME_CHECK_EN
   logic                   ferr_q, ferr_d;
`endif

   logic sclk_s, data_s, latch_s;
   logic armed, sclk_rise, latch_rise;

   assign sclk_s  = sclk_sync_q[SYNC_STAGES-1];
   assign data_s  = data_sync_q[SYNC_STAGES-1];
   assign latch_s = latch_sync_q[SYNC_STAGES-1];

   // Edges stay blind until the chains and the history flops hold real pin levels.
   assign armed      = (mask_q == MASK_LAST);
   assign sclk_rise  = armed & sclk_s & ~sclk_prev_q;
   assign latch_rise = armed & latch_s & ~latch_prev_q;

   always_comb begin
      sclk_sync_d  = {sclk_sync_q[SYNC_STAGES-2:0], i_SCLK};
      data_sync_d  = {data_sync_q[SYNC_STAGES-2:0], i_SData};
      latch_sync_d = {latch_sync_q[SYNC_STAGES-2:0], i_SLatch};
      sclk_prev_d  = sclk_s;
      latch_prev_d = latch_s;
      mask_d       = armed ? mask_q : mask_q + MW'(1);
      shreg_d      = shreg_q;
      count_d      = count_q;
      ovr_d        = ovr_q;
      data_d       = data_q;
      valid_d      = 1'b0;
`ifdef LED_RX_FRAME_CHECK_EN
      ferr_d       = 1'b0;
`endif

      if (sclk_rise) begin
         shreg_d = {shreg_q[WIDTH-2:0], data_s};
      end

      // A shift that arrives with the latch is the first bit of the next frame.
      if (latch_rise) begin
         count_d = sclk_rise ? CNT_ONE : '0;
         ovr_d   = 1'b0;
`ifdef LED_RX_FRAME_CHECK_EN
         if ((count_q == CNT_FULL) && !ovr_q) begin
            data_d  = shreg_q;
            valid_d = 1'b1;
         end else begin
            ferr_d  = 1'b1;
         end
`else
         data_d  = shreg_q;
         valid_d = 1'b1;
`endif
      end else if (sclk_rise) begin
         if (count_q == CNT_FULL) begin
            ovr_d = 1'b1;
         end else begin
            count_d = count_q + CNT_ONE;
         end
      end
   end

   always_ff @(posedge i_CLK or negedge i_RESET) begin
      if (!i_RESET) begin
         sclk_sync_q  <= '0;
         data_sync_q  <= '0;
         latch_sync_q <= '0;
         sclk_prev_q  <= 1'b0;
         latch_prev_q <= 1'b0;
         mask_q       <= '0;
         shreg_q      <= '0;
         count_q      <= '0;
         ovr_q        <= 1'b0;
         data_q       <= '0;
         valid_q      <= 1'b0;
`ifdef LED_RX_FRAME_CHECK_EN
         ferr_q       <= 1'b0;
`endif
      end else begin
         sclk_sync_q  <= sclk_sync_d;
         data_sync_q  <= data_sync_d;
         latch_sync_q <= latch_sync_d;
         sclk_prev_q  <= sclk_prev_d;
         latch_prev_q <= latch_prev_d;
         mask_q       <= mask_d;
         shreg_q      <= shreg_d;
         count_q      <= count_d;
         ovr_q        <= ovr_d;
         data_q       <= data_d;
         valid_q      <= valid_d;
`ifdef LED_RX_FRAME_CHECK_EN
         ferr_q       <= ferr_d;
`endif
      end
   end

   assign o_Data     = data_q;
   assign o_Valid    = valid_q;
   assign o_BitCount = count_q;
`ifdef LED_RX_FRAME_CHECK_EN
   assign o_FrameErr = ferr_q;
`else
   assign o_FrameErr = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_led_serial_receiver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_led_serial_receiver
//  Purpose  : Scoreboard bench for led_serial_receiver. It uses directed
//             frames, and a monitor checks each commit against the queue.
//  Revision : 1.0  initial release
// ============================================================================
module tb_led_serial_receiver;

   localparam int W = 16;

   typedef struct {
      bit         err;
      logic [W-1:0] data;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         sclk = 1'b0;
   logic         sdata = 1'b0;
   logic         slatch = 1'b0;
   logic [W-1:0] o_data;
   logic         o_valid;
   logic [4:0]   o_bitcount;
   logic         o_ferr;

   int   checks = 0;
   int   errors = 0;
   exp_t exp_q[$];

   led_serial_receiver #(.WIDTH(W), .SYNC_STAGES(2)) dut (
      .i_CLK      (clk),
      .i_RESET    (rst_n),
      .i_SCLK     (sclk),
      .i_SData    (sdata),
      .i_SLatch   (slatch),
      .o_Data     (o_data),
      .o_Valid    (o_valid),
      .o_BitCount (o_bitcount),
      .o_FrameErr (o_ferr)
   );

   always #10 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic push_exp(input bit err, input logic [W-1:0] data);
      exp_t e;
      e.err  = err;
      e.data = data;
      exp_q.push_back(e);
   endtask

   // Monitor: every valid or frame-error pulse must match the oldest expectation.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && (o_valid || o_ferr)) begin
         if (o_valid && o_ferr) begin
            check("valid_ferr_exclusive", {31'd0, o_valid & o_ferr}, 32'd0);
         end else if (exp_q.size() == 0) begin
            check("unexpected_output", {30'd0, o_valid, o_ferr}, 32'd0);
         end else begin
            e = exp_q.pop_front();
            check("commit_kind_ferr", {31'd0, o_ferr}, {31'd0, e.err});
            check("commit_data", {16'd0, o_data}, {16'd0, e.data});
         end
      end
   end

   task automatic send_bit(input logic b);
      @(negedge clk); sdata = b;
      repeat (2) @(negedge clk); sclk = 1'b1;
      repeat (5) @(negedge clk); sclk = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic send_word(input logic [31:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
   endtask

   // Latch pulse; with chk_lat the valid pulse must appear on exactly the third cycle.
   task automatic do_latch(input bit chk_lat);
      @(negedge clk); slatch = 1'b1;
      if (chk_lat) begin
         for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check("latch_latency_valid", {31'd0, o_valid}, (i == 3) ? 32'd1 : 32'd0);
         end
         @(negedge clk);
      end else begin
         repeat (5) @(negedge clk);
      end
      slatch = 1'b0;
      repeat (6) @(negedge clk);
   endtask

   initial begin
      #1;
      check("reset_data", {16'd0, o_data}, 32'd0);
      check("reset_valid", {31'd0, o_valid}, 32'd0);
      check("reset_count", {27'd0, o_bitcount}, 32'd0);
      check("reset_ferr", {31'd0, o_ferr}, 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      // Test 1: full frame 0xA5C3
      send_word(32'hA5C3, 16);
      check("t1_count_full", {27'd0, o_bitcount}, 32'd16);
      push_exp(1'b0, 16'hA5C3);
      do_latch(1'b1);
      check("t1_count_cleared", {27'd0, o_bitcount}, 32'd0);

      // Test 2: short frame of eight ones
      send_word(32'hFF, 8);
      check("t2_count8", {27'd0, o_bitcount}, 32'd8);
`ifdef LED_RX_FRAME_CHECK_EN
      push_exp(1'b1, 16'hA5C3);
`else
      push_exp(1'b0, 16'hC3FF);
`endif
      do_latch(1'b0);

      // Test 3: 17 bits, 1 then 0x1234
      send_bit(1'b1);
      send_word(32'h1234 >> 1, 15);
      check("t3_count16", {27'd0, o_bitcount}, 32'd16);
      send_bit(1'b0);
      check("t3_count_sat", {27'd0, o_bitcount}, 32'd16);
`ifdef LED_RX_FRAME_CHECK_EN
      push_exp(1'b1, 16'hA5C3);
`else
      push_exp(1'b0, 16'h1234);
`endif
      do_latch(1'b0);

      // Test 4: 15 ones, then the 16th shift coincides with the latch
      send_word(32'h7FFF, 15);
      check("t4_count15", {27'd0, o_bitcount}, 32'd15);
      @(negedge clk); sdata = 1'b0;
      repeat (2) @(negedge clk);
      sclk = 1'b1; slatch = 1'b1;
`ifdef LED_RX_FRAME_CHECK_EN
      push_exp(1'b1, 16'hA5C3);
`else
      push_exp(1'b0, 16'h7FFF);
`endif
      repeat (5) @(negedge clk);
      sclk = 1'b0; slatch = 1'b0;
      repeat (5) @(negedge clk);
      check("t4_count_after", {27'd0, o_bitcount}, 32'd1);

      // Test 5: reset mid-frame, then a clean frame
      send_word(32'h1FF, 9);
      check("t5_count9", {27'd0, o_bitcount}, 32'd10);
      @(negedge clk); rst_n = 1'b0;
      #1;
      check("t5_rst_data", {16'd0, o_data}, 32'd0);
      check("t5_rst_count", {27'd0, o_bitcount}, 32'd0);
      repeat (3) @(negedge clk); rst_n = 1'b1;
      repeat (10) @(negedge clk);
      check("t5_count_post_rst", {27'd0, o_bitcount}, 32'd0);
      send_word(32'h0F0F, 16);
      push_exp(1'b0, 16'h0F0F);
      do_latch(1'b0);

      // Test 6: SCLK held high through reset release
      @(negedge clk); sclk = 1'b1; rst_n = 1'b0;
      repeat (3) @(negedge clk); rst_n = 1'b1;
      repeat (10) @(negedge clk);
      check("t6_count_sclk_high", {27'd0, o_bitcount}, 32'd0);
      check("t6_data_zero", {16'd0, o_data}, 32'd0);
      sclk = 1'b0;
      repeat (10) @(negedge clk);
      check("t6_count_after_fall", {27'd0, o_bitcount}, 32'd0);

      // Back-to-back latches with no shifts
`ifdef LED_RX_FRAME_CHECK_EN
      push_exp(1'b1, 16'h0000);
      do_latch(1'b0);
      push_exp(1'b1, 16'h0000);
      do_latch(1'b0);
`else
      push_exp(1'b0, 16'h0000);
      do_latch(1'b0);
      push_exp(1'b0, 16'h0000);
      do_latch(1'b0);
`endif

      repeat (20) @(negedge clk);
      check("exp_queue_drained", exp_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

endmodule
`default_nettype wire
